// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Generates 640x480@60 Hz VGA timing from the 50 MHz board clock. A pixel
//   tick divider advances horizontal/vertical counters; the current (x,y) is
//   exported to the pixel source, the returned RGB332 colour is blanked
//   outside the visible area, and colour plus hsync/vsync are registered
//   together so they reach the pins aligned (one clk after x,y change).
//
// Optional feature:
//   VGA_FRAME_COUNT_EN - when defined, adds output frame_cnt[5:0], a
//   free-running count of frame_start pulses (wraps 63->0, resets to 0).
//
// Ports:
//   clk          in   system clock (50 MHz)
//   rst          in   asynchronous active-high reset; release is expected
//                     to be synchronous to clk
//   pixel_in     in   [7:0] RGB332 colour for current (x,y), comb. from x/y
//   x            out  [9:0] horizontal count, 0..H_TOTAL-1
//   y            out  [9:0] vertical count, 0..V_TOTAL-1
//   pix_tick     out  one-clk pulse; counters advance on this cycle
//   video_on     out  x<H_ACTIVE && y<V_ACTIVE (combinational)
//   frame_start  out  one-clk pulse on the tick that wraps to (0,0)
//   red/green    out  [2:0] registered, blanked colour
//   blue         out  [1:0] registered, blanked colour
//   hsync/vsync  out  registered sync outputs
//   frame_cnt    out  [5:0] frame counter (VGA_FRAME_COUNT_EN only)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int CLK_DIV         = 2,
   parameter int H_ACTIVE        = 640,
   parameter int H_FP            = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BP            = 48,
   parameter int V_ACTIVE        = 480,
   parameter int V_FP            = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BP            = 33,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] pixel_in,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       pix_tick,
   output logic       video_on,
   output logic       frame_start,
   output logic [2:0] red,
   output logic [2:0] green,
   output logic [1:0] blue,
   output logic       hsync,
   output logic       vsync
`ifdef VGA_FRAME_COUNT_EN
   ,
   output logic [5:0] frame_cnt
`endif
);

   localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
   localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
   localparam logic       SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
         $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counters");
      end
      if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_div
         $fatal(1, "vga_timing_gen: CLK_DIV must be 1..8");
      end
   endgenerate

   logic [2:0] r_div;
   logic [9:0] r_x;
   logic [9:0] r_y;
   logic [2:0] r_red;
   logic [2:0] r_green;
   logic [1:0] r_blue;
   logic       r_hsync;
   logic       r_vsync;

   logic       w_div_last;
   logic       w_x_last;
   logic       w_y_last;
   logic       w_hwin;
   logic       w_vwin;

   assign w_div_last = (r_div == DIV_LAST);
   assign w_x_last   = (r_x == X_LAST);
   assign w_y_last   = (r_y == Y_LAST);

   // Gated by rst so that with CLK_DIV=1 the tick stays low while in reset.
   assign pix_tick    = w_div_last & ~rst;
   assign frame_start = pix_tick & w_x_last & w_y_last;

   // 11-bit compares keep window ends of exactly 1024 representable.
   assign video_on = ({1'b0, r_x} < 11'(H_ACTIVE)) && ({1'b0, r_y} < 11'(V_ACTIVE));
   assign w_hwin   = ({1'b0, r_x} >= 11'(H_SYNC_START)) && ({1'b0, r_x} < 11'(H_SYNC_END));
   assign w_vwin   = ({1'b0, r_y} >= 11'(V_SYNC_START)) && ({1'b0, r_y} < 11'(V_SYNC_END));

   // Pixel divider and raster counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div <= 3'd0;
         r_x   <= 10'd0;
         r_y   <= 10'd0;
      end else begin
         r_div <= w_div_last ? 3'd0 : r_div + 3'd1;
         if (pix_tick) begin
            if (w_x_last) begin
               r_x <= 10'd0;
               r_y <= w_y_last ? 10'd0 : r_y + 10'd1;
            end else begin
               r_x <= r_x + 10'd1;
            end
         end
      end
   end

   // Output stage: colour and sync sampled from the same counter values so
   // they stay aligned at the pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_red   <= 3'd0;
         r_green <= 3'd0;
         r_blue  <= 2'd0;
         r_hsync <= SYNC_IDLE;
         r_vsync <= SYNC_IDLE;
      end else begin
         r_red   <= video_on ? pixel_in[7:5] : 3'd0;
         r_green <= video_on ? pixel_in[4:2] : 3'd0;
         r_blue  <= video_on ? pixel_in[1:0] : 2'd0;
         r_hsync <= w_hwin ? ~SYNC_IDLE : SYNC_IDLE;
         r_vsync <= w_vwin ? ~SYNC_IDLE : SYNC_IDLE;
      end
   end

   assign x     = r_x;
   assign y     = r_y;
   assign red   = r_red;
   assign green = r_green;
   assign blue  = r_blue;
   assign hsync = r_hsync;
   assign vsync = r_vsync;

`ifdef VGA_FRAME_COUNT_EN
   logic [5:0] r_frame_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_cnt <= 6'd0;
      end else if (frame_start) begin
         r_frame_cnt <= r_frame_cnt + 6'd1;
      end
   end

   assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Uses a shrunken raster (15x8 positions, CLK_DIV=2 -> 240 clks per frame)
// so full frames fit in a short run. Expected per-cycle outputs are derived
// in closed form from the number of clocks since reset release.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int D     = 2;
   localparam int HA    = 8;
   localparam int HF    = 2;
   localparam int HS    = 3;
   localparam int HB    = 2;
   localparam int VA    = 4;
   localparam int VF    = 1;
   localparam int VS    = 2;
   localparam int VB    = 1;
   localparam int HT    = HA + HF + HS + HB;  // 15
   localparam int VT    = VA + VF + VS + VB;  // 8
   localparam int FRAME = D * HT * VT;        // 240

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pixel_in;
   logic [9:0] x;
   logic [9:0] y;
   logic       pix_tick;
   logic       video_on;
   logic       frame_start;
   logic [2:0] red;
   logic [2:0] green;
   logic [1:0] blue;
   logic       hsync;
   logic       vsync;
`ifdef VGA_FRAME_COUNT_EN
   logic [5:0] frame_cnt;
`endif

   int total = 0;
   int bad   = 0;
   int mode  = 0;
   int t_cnt = 0;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       tick;
      logic       fs;
      logic       von;
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
      logic       hs;
      logic       vs;
      logic [5:0] fc;
   } exp_t;

   exp_t exp_q[$];

   vga_timing_gen #(
      .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE_LOW(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pixel_in(pixel_in),
      .x(x),
      .y(y),
      .pix_tick(pix_tick),
      .video_on(video_on),
      .frame_start(frame_start),
      .red(red),
      .green(green),
      .blue(blue),
      .hsync(hsync),
      .vsync(vsync)
`ifdef VGA_FRAME_COUNT_EN
      ,
      .frame_cnt(frame_cnt)
`endif
   );

   // ---------------- clock / reset bookkeeping ----------------
   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) t_cnt <= 0;
      else     t_cnt <= t_cnt + 1;
   end

   // ---------------- pixel source ----------------
   function automatic logic [7:0] pat(input int m, input int px, input int py);
      logic [9:0] xv;
      logic [9:0] yv;
      xv = 10'(px);
      yv = 10'(py);
      if (m == 0) return 8'hFF;
      return {xv[2:0], yv[2:0], xv[1:0] ^ yv[1:0]};
   endfunction

   assign pixel_in = pat(mode, int'(x), int'(y));

   // ---------------- reference model ----------------
   function automatic exp_t model(input int t, input int m);
      exp_t e;
      int p, pp, cx, cy, px, py;
      logic [7:0] c;
      p    = t / D;
      cx   = p % HT;
      cy   = (p / HT) % VT;
      e.x  = 10'(cx);
      e.y  = 10'(cy);
      e.tick = ((t % D) == D - 1);
      e.fs   = e.tick && (cx == HT - 1) && (cy == VT - 1);
      e.von  = (cx < HA) && (cy < VA);
      pp = (t - 1) / D;
      px = pp % HT;
      py = (pp / HT) % VT;
      c  = ((px < HA) && (py < VA)) ? pat(m, px, py) : 8'h00;
      e.r  = c[7:5];
      e.g  = c[4:2];
      e.b  = c[1:0];
      e.hs = !((px >= HA + HF) && (px < HA + HF + HS));
      e.vs = !((py >= VA + VF) && (py < VA + VF + VS));
      e.fc = 6'((t / FRAME) % 64);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t_cnt);
      end
   endtask

   // ---------------- scoreboard: push side ----------------
   always @(posedge clk) begin
      #1;
      if (!rst) exp_q.push_back(model(t_cnt, mode));
   end

   // ---------------- scoreboard: monitor side ----------------
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         exp_q.delete();
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("x", 32'(x), 32'(e.x));
         check("y", 32'(y), 32'(e.y));
         check("pix_tick", 32'(pix_tick), 32'(e.tick));
         check("frame_start", 32'(frame_start), 32'(e.fs));
         check("video_on", 32'(video_on), 32'(e.von));
         check("red", 32'(red), 32'(e.r));
         check("green", 32'(green), 32'(e.g));
         check("blue", 32'(blue), 32'(e.b));
         check("hsync", 32'(hsync), 32'(e.hs));
         check("vsync", 32'(vsync), 32'(e.vs));
`ifdef VGA_FRAME_COUNT_EN
         check("frame_cnt", 32'(frame_cnt), 32'(e.fc));
`endif
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_x"}, 32'(x), 0);
      check({tag, "_y"}, 32'(y), 0);
      check({tag, "_tick"}, 32'(pix_tick), 0);
      check({tag, "_fs"}, 32'(frame_start), 0);
      check({tag, "_rgb"}, 32'({red, green, blue}), 0);
      check({tag, "_hsync"}, 32'(hsync), 1);
      check({tag, "_vsync"}, 32'(vsync), 1);
`ifdef VGA_FRAME_COUNT_EN
      check({tag, "_fcnt"}, 32'(frame_cnt), 0);
`endif
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int hs_low, vs_low, fs_cnt, von_cnt, white_cnt, wrap_at, n, found;
      rst  = 1'b1;
      mode = 0;
      repeat (2) @(negedge clk);
      check_reset_values("por");
      #2 rst = 1'b0;

      // One frame with constant white input: samples t=1..240.
      hs_low = 0; vs_low = 0; fs_cnt = 0; von_cnt = 0; white_cnt = 0; wrap_at = -1;
      for (int i = 1; i <= FRAME; i++) begin
         @(negedge clk);
         if (hsync == 1'b0) hs_low++;
         if (vsync == 1'b0) vs_low++;
         if (frame_start) fs_cnt++;
         if (video_on) von_cnt++;
         if ({red, green, blue} == 8'hFF) white_cnt++;
         if (wrap_at < 0 && y == 10'd1) wrap_at = i;
      end
      check("line_wrap_clk", 32'(wrap_at), 30);
      check("hsync_low_clks", 32'(hs_low), 48);
      check("vsync_low_clks", 32'(vs_low), 60);
      check("frame_start_cnt", 32'(fs_cnt), 1);
      check("video_on_clks", 32'(von_cnt), 64);
      check("white_clks", 32'(white_cnt), 64);

      // Second frame with a coordinate-dependent pattern.
      #2 mode = 1;
      repeat (FRAME) @(negedge clk);

      // Mid-frame reset at (5,2).
      found = 0;
      for (int i = 0; i < 2 * FRAME && found == 0; i++) begin
         @(negedge clk);
         if (x == 10'd5 && y == 10'd2) found = 1;
      end
      check("mid_found", 32'(found), 1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1 check_reset_values("mid");
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;

      // No frame_start for the aborted frame; next one a full frame later.
      n = 0;
      found = 0;
      for (int i = 1; i <= FRAME + 20 && found == 0; i++) begin
         @(negedge clk);
         if (frame_start) begin
            found = 1;
            n = i;
         end
      end
      check("fs_after_reset_clk", 32'(n), FRAME - 1);

`ifdef VGA_FRAME_COUNT_EN
      // Continue to 65 completed frames since release: counter passes 63->0.
      repeat (65 * FRAME - (FRAME - 1)) @(negedge clk);
      check("frame_cnt_65", 32'(frame_cnt), 1);
`endif

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA timing from the 50 MHz board clock and drives the RGB332 pixel bus of the top-level display stage.
- Holds horizontal and vertical counters and a pixel-tick divider.
- Exports the current pixel coordinates to the upstream pixel source.
- Takes back an 8-bit colour, blanks it outside the active area, and registers it together with hsync/vsync so colour and sync stay aligned at the pins.

Parameters:
CLK_DIV, 2, system clocks per pixel (pixel tick period); legal values 1..8
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch, pixels
H_SYNC, 96, horizontal sync width, pixels
H_BP, 48, horizontal back porch, pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch, lines
V_SYNC, 2, vertical sync width, lines
V_BP, 33, vertical back porch, lines
SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync are low during the sync pulse

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
pixel_in  in  8  colour for current (x,y), RGB332 {r[2:0],g[2:0],b[1:0]}; combinational from x/y
x  out  10  current horizontal count, 0..H_TOTAL-1
y  out  10  current vertical count, 0..V_TOTAL-1
pix_tick  out  1  one-clk pulse; counters advance on this cycle
video_on  out  1  high when x<H_ACTIVE and y<V_ACTIVE (combinational from counters)
frame_start  out  1  one-clk pulse when counters wrap to (0,0)
red  out  3  registered, blanked red
green  out  3  registered, blanked green
blue  out  2  registered, blanked blue
hsync  out  1  registered horizontal sync
vsync  out  1  registered vertical sync

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (async assert, sync release):
  - div counter = 0; x = 0; y = 0.
  - red/green/blue = 0.
  - hsync/vsync = inactive level (1 when SYNC_ACTIVE_LOW=1).
  - pix_tick = 0; frame_start = 0.
- Divider:
  - Counts 0..CLK_DIV-1.
  - pix_tick is high on the clk where div == CLK_DIV-1.
  - With CLK_DIV=1, pix_tick is constantly high after reset.
- Counter advance (on a pix_tick cycle):
  - If x == H_TOTAL-1: x <= 0, and y advances (y == V_TOTAL-1 wraps to 0, else y+1).
  - Otherwise x <= x+1.
  - Counters hold when pix_tick is low.
- frame_start is high on the pix_tick cycle where x == H_TOTAL-1 and y == V_TOTAL-1, i.e. the clk before x,y read 0,0.
- Sync windows (combinational from the counters):
  - Horizontal: H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - Vertical: V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
  - Polarity applied per SYNC_ACTIVE_LOW.
- Output pipeline, one-clk latency:
  - Every clk: red/green/blue <= video_on ? pixel_in fields : 0.
  - hsync/vsync are registered from the same-cycle counters.
  - Colour and sync therefore describe the same (x,y), one clk after x,y change.
- Widths:
  - Counters are 10 bits.
  - Any parameter set giving H_TOTAL or V_TOTAL > 1024 is illegal; elaboration asserts.
- Reset mid-frame: outputs go to reset values immediately; after release, counting restarts at (0,0) with no frame_start for the aborted frame.

Optional Feature:
Macro VGA_FRAME_COUNT_EN.
- Defined:
  - Adds output port frame_cnt [5:0].
  - Increments on every frame_start and wraps 63->0; reset 0.
  - Intended for the top-level led_debugging LEDs.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, CLK_DIV=2 -> pix_tick every 2nd clk; x/y read 0/0; hsync=vsync=1; rgb=0.
- Run one line -> x wraps 799->0 after 1600 clks; y 0->1; hsync low exactly for x=656..751 (192 clks).
- Run one full frame -> frame_start pulses once per 840000 clks; vsync low for y=490..491 (3200 clks).
- Drive pixel_in=8'hFF constantly -> red=7, green=7, blue=3 for x<640,y<480 one clk after counters; 0 at x=640..799 and y>=480.
- Assert rst at x=300,y=200 -> outputs reset asynchronously; after release counting resumes from (0,0); next frame_start 840000 clks later.
- With VGA_FRAME_COUNT_EN defined, run 65 frames -> frame_cnt reads 1, passing 63->0.
